demux_stream_1x4: RTL and testbench

Registered 1-to-N stream demultiplexer: one valid/ready input stream is steered, per transfer, to one of OUT_NUM valid/ready output channels selected by a sideband select. Each output channel owns a one-entry holding register, so every output is registered and a stalled channel does not block transfers to other channels. It is the distribution counterpart of the team's N-to-1 mux blocks: the mux gathers many sources into one, and this block fans one source out to many sinks.

---
 rtl/demux_stream_1x4.sv | 83 ++++++++
 tb/tb_demux_stream_1x4.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_stream_1x4.sv
// Registered 1-to-N valid/ready stream demultiplexer.
// Each output channel has its own one-entry holding register, so a stalled sink only blocks words addressed to it.
module demux_stream_1x4 #(
    parameter int unsigned OUT_NUM = 4,
    parameter int unsigned SEL_NUM = $clog2(OUT_NUM),
    parameter int unsigned DATA_W  = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [DATA_W-1:0]           in_data_i,
    input  logic [SEL_NUM-1:0]          in_sel_i,
    output logic [OUT_NUM-1:0]          out_valid_o,
    input  logic [OUT_NUM-1:0]          out_ready_i,
    output logic [OUT_NUM*DATA_W-1:0]   out_data_o,
    output logic                        sel_err_o
);

    logic [OUT_NUM-1:0]             valid_q, valid_d;
    logic [OUT_NUM-1:0][DATA_W-1:0] data_q,  data_d;
    logic                           sel_err_q, sel_err_d;

    logic sel_ok_c;
    logic tgt_valid_c;
    logic tgt_ready_c;
    logic in_ready_c;
    logic accept_c;

    // Look up the addressed channel and decide whether the offered word can be taken.
    always_comb begin
        sel_ok_c    = (int'(in_sel_i) < int'(OUT_NUM));
        tgt_valid_c = 1'b0;
        tgt_ready_c = 1'b0;
        for (int k = 0; k < int'(OUT_NUM); k++) begin
            if (int'(in_sel_i) == k) begin
                tgt_valid_c = valid_q[k];
                tgt_ready_c = out_ready_i[k];
            end
        end
        if (rst_i) begin
            in_ready_c = 1'b0;
        end else if (!sel_ok_c) begin
            in_ready_c = 1'b1;
        end else begin
            in_ready_c = !tgt_valid_c || tgt_ready_c;
        end
        accept_c = in_valid_i && in_ready_c;
    end

    // Per-channel holding register: a load wins over a drain so back-to-back words flow.
    always_comb begin
        valid_d   = valid_q;
        data_d    = data_q;
        sel_err_d = accept_c && !sel_ok_c;
        for (int k = 0; k < int'(OUT_NUM); k++) begin
            if (accept_c && sel_ok_c && (int'(in_sel_i) == k)) begin
                valid_d[k] = 1'b1;
                data_d[k]  = in_data_i;
            end else if (valid_q[k] && out_ready_i[k]) begin
                valid_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q   <= '0;
            data_q    <= '0;
            sel_err_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign in_ready_o  = in_ready_c;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign sel_err_o   = sel_err_q;

endmodule

// File: tb/tb_demux_stream_1x4.sv
// Directed bench for demux_stream_1x4: a 4-channel instance for routing/stall/reset
// and a 3-channel instance for out-of-range select handling.
module tb_demux_stream_1x4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 4-channel instance
    logic        a_in_valid, a_in_ready;
    logic [7:0]  a_in_data;
    logic [1:0]  a_in_sel;
    logic [3:0]  a_out_valid, a_out_ready;
    logic [31:0] a_out_data;
    logic        a_sel_err;

    // 3-channel instance
    logic        b_in_valid, b_in_ready;
    logic [7:0]  b_in_data;
    logic [1:0]  b_in_sel;
    logic [2:0]  b_out_valid, b_out_ready;
    logic [23:0] b_out_data;
    logic        b_sel_err;

    demux_stream_1x4 #(.OUT_NUM(4), .SEL_NUM(2), .DATA_W(8)) u_dut_a (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
        .in_data_i(a_in_data), .in_sel_i(a_in_sel),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
        .out_data_o(a_out_data), .sel_err_o(a_sel_err)
    );

    demux_stream_1x4 #(.OUT_NUM(3), .SEL_NUM(2), .DATA_W(8)) u_dut_b (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
        .in_data_i(b_in_data), .in_sel_i(b_in_sel),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
        .out_data_o(b_out_data), .sel_err_o(b_sel_err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] a_ch(input int k);
        return a_out_data[k*8 +: 8];
    endfunction

    initial begin
        rst         = 1'b1;
        a_in_valid  = 1'b1;
        a_in_sel    = 2'd0;
        a_in_data   = 8'h77;
        a_out_ready = 4'b0000;
        b_in_valid  = 1'b0;
        b_in_sel    = 2'd0;
        b_in_data   = 8'h00;
        b_out_ready = 3'b000;

        // Reset held two cycles with an offered word
        tick();
        tick();
        check_eq("rst_in_ready", 32'(a_in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(a_out_valid), 32'd0);
        check_eq("rst_out_data", a_out_data, 32'd0);
        check_eq("rst_sel_err", 32'(a_sel_err), 32'd0);
        check_eq("rst_b_out_valid", 32'(b_out_valid), 32'd0);
        rst        = 1'b0;
        a_in_valid = 1'b0;
        #1;
        check_eq("rel_in_ready", 32'(a_in_ready), 32'd1);

        // Routing to every channel with all sinks ready
        a_out_ready = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            a_in_valid = 1'b1;
            a_in_sel   = 2'(k);
            a_in_data  = 8'hA0 + 8'(k);
            #1;
            check_eq($sformatf("route_ready%0d", k), 32'(a_in_ready), 32'd1);
            tick();
            check_eq($sformatf("route_valid%0d", k), 32'(a_out_valid), 32'(4'b0001 << k));
            check_eq($sformatf("route_data%0d", k), 32'(a_ch(k)), 32'(8'hA0 + 8'(k)));
        end
        a_in_valid = 1'b0;
        tick();
        check_eq("route_empty", 32'(a_out_valid), 32'd0);

        // Stall isolation on channel 2
        a_out_ready = 4'b1011;
        a_in_valid  = 1'b1;
        a_in_sel    = 2'd2;
        a_in_data   = 8'h55;
        #1;
        check_eq("stall_first_ready", 32'(a_in_ready), 32'd1);
        tick();
        check_eq("stall_valid", 32'(a_out_valid), 32'b0100);
        check_eq("stall_data", 32'(a_ch(2)), 32'h55);
        a_in_data = 8'h77;
        #1;
        check_eq("stall_blocked", 32'(a_in_ready), 32'd0);
        tick();
        check_eq("stall_hold_valid", 32'(a_out_valid), 32'b0100);
        check_eq("stall_hold_data", 32'(a_ch(2)), 32'h55);
        a_in_sel  = 2'd1;
        a_in_data = 8'h66;
        #1;
        check_eq("stall_other_ready", 32'(a_in_ready), 32'd1);
        tick();
        check_eq("stall_other_valid", 32'(a_out_valid), 32'b0110);
        check_eq("stall_other_data", 32'(a_ch(1)), 32'h66);
        check_eq("stall_ch2_intact", 32'(a_ch(2)), 32'h55);
        a_in_sel    = 2'd2;
        a_in_data   = 8'h77;
        a_out_ready = 4'b1111;
        #1;
        check_eq("unstall_ready", 32'(a_in_ready), 32'd1);
        tick();
        check_eq("unstall_valid", 32'(a_out_valid), 32'b0100);
        check_eq("unstall_data", 32'(a_ch(2)), 32'h77);
        a_in_valid = 1'b0;
        tick();
        check_eq("unstall_drained", 32'(a_out_valid), 32'd0);
        check_eq("drained_data_held", 32'(a_ch(2)), 32'h77);

        // Continuous stream into channel 3: drain and load in the same cycle
        for (int i = 0; i < 8; i++) begin
            a_in_valid = 1'b1;
            a_in_sel   = 2'd3;
            a_in_data  = 8'h10 + 8'(i);
            #1;
            check_eq($sformatf("stream_ready%0d", i), 32'(a_in_ready), 32'd1);
            tick();
            check_eq($sformatf("stream_valid%0d", i), 32'(a_out_valid), 32'b1000);
            check_eq($sformatf("stream_data%0d", i), 32'(a_ch(3)), 32'(8'h10 + 8'(i)));
        end
        a_in_valid = 1'b0;
        tick();
        check_eq("stream_empty", 32'(a_out_valid), 32'd0);
        check_eq("a_no_sel_err", 32'(a_sel_err), 32'd0);

        // Out-of-range select on the 3-channel instance
        b_in_valid = 1'b1;
        b_in_sel   = 2'd0;
        b_in_data  = 8'h11;
        tick();
        check_eq("oor_pre_valid", 32'(b_out_valid), 32'b001);
        b_in_sel  = 2'd3;
        b_in_data = 8'hEE;
        #1;
        check_eq("oor_ready", 32'(b_in_ready), 32'd1);
        check_eq("oor_err_before", 32'(b_sel_err), 32'd0);
        tick();
        check_eq("oor_err_pulse", 32'(b_sel_err), 32'd1);
        check_eq("oor_valid_same", 32'(b_out_valid), 32'b001);
        check_eq("oor_data_same", b_out_data, 32'h000011);
        b_in_valid = 1'b0;
        tick();
        check_eq("oor_err_end", 32'(b_sel_err), 32'd0);
        check_eq("oor_valid_after", 32'(b_out_valid), 32'b001);

        // Reset mid-operation with channels 0 and 1 full
        a_out_ready = 4'b0000;
        a_in_valid  = 1'b1;
        a_in_sel    = 2'd0;
        a_in_data   = 8'hC0;
        tick();
        a_in_sel  = 2'd1;
        a_in_data = 8'hC1;
        tick();
        check_eq("mid_full_valid", 32'(a_out_valid), 32'b0011);
        check_eq("mid_full_data", 32'(a_out_data[15:0]), 32'hC1C0);
        rst       = 1'b1;
        a_in_sel  = 2'd2;
        a_in_data = 8'hDD;
        #1;
        check_eq("mid_rst_ready", 32'(a_in_ready), 32'd0);
        tick();
        check_eq("mid_rst_valid", 32'(a_out_valid), 32'd0);
        check_eq("mid_rst_data", a_out_data, 32'd0);
        check_eq("mid_rst_b_valid", 32'(b_out_valid), 32'd0);
        rst         = 1'b0;
        a_in_valid  = 1'b0;
        a_out_ready = 4'b1111;
        tick();
        check_eq("post_rst_valid0", 32'(a_out_valid), 32'd0);
        tick();
        check_eq("post_rst_valid1", 32'(a_out_valid), 32'd0);
        check_eq("post_rst_data", a_out_data, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
